// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  // Cycles needed after the last operand beat for every PE to see its final term.
  function automatic int drain_cycles(input int n);
    return 3 * n - 2;
  endfunction

  // Row-major flat index of element (i,j) in an n-wide matrix.
  function automatic int flat_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Job control, operand stream and result bus of the systolic engine.
interface systolic_matmul_engine_if #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_MAX  = 255
) ();
  localparam int KW = $clog2(K_MAX + 1);

  logic                     start;
  logic [KW-1:0]            k_len;
  logic                     signed_mode;
  logic                     busy;
  logic                     in_valid;
  logic                     in_ready;
  logic [N*DATA_W-1:0]      a_col;
  logic [N*DATA_W-1:0]      b_row;
  logic                     done;
  logic                     result_valid;
  logic [N*N*ACC_W-1:0]     c_flat;

  modport master (
    output start, k_len, signed_mode, in_valid, a_col, b_row,
    input  busy, in_ready, done, result_valid, c_flat
  );

  modport slave (
    input  start, k_len, signed_mode, in_valid, a_col, b_row,
    output busy, in_ready, done, result_valid, c_flat
  );
endinterface

// File: rtl/systolic_pe.sv
// One output-stationary MAC cell: forwards a right and b down, accumulates a*b.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              signed_mode,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);
  // One extra top bit carries the sign (signed mode) or a zero (unsigned mode),
  // so a single signed multiplier covers both operand formats.
  logic signed [DATA_W:0]     a_x;
  logic signed [DATA_W:0]     b_x;
  logic signed [2*DATA_W+1:0] prod;
  logic [ACC_W-1:0]           prod_ext;

  assign a_x      = {signed_mode & a_in[DATA_W-1], a_in};
  assign b_x      = {signed_mode & b_in[DATA_W-1], b_in};
  assign prod     = a_x * b_x;
  assign prod_ext = ACC_W'(prod);

  // Operand forwarding and wrap-around accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clear) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end
endmodule

// File: rtl/systolic_matmul_engine.sv
// N x N output-stationary systolic matmul with input skew and job controller.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int K_MAX  = 255
) (
  input logic                     clk,
  input logic                     rst,
  systolic_matmul_engine_if.slave bus
);
  localparam int KW        = $clog2(K_MAX + 1);
  localparam int DRAIN_LEN = drain_cycles(N);
  localparam int DCW       = $clog2(DRAIN_LEN);

  state_t               state_reg, state_next;
  logic [KW-1:0]        beats_left_reg;
  logic [DCW-1:0]       drain_cnt_reg;
  logic                 signed_mode_reg;
  logic                 done_reg;
  logic                 beat;
  logic                 pe_clear;
  logic                 pe_en;
  logic                 busy_c;
  logic                 ready_c;
  logic                 rvalid_c;

  logic [DATA_W-1:0]    a_h [N][N+1];
  logic [DATA_W-1:0]    b_v [N+1][N];
  logic [N-1:0]         unused_a_edge;
  logic [N-1:0]         unused_b_edge;
  logic [N*N*ACC_W-1:0] c_flat_w;

  assign beat     = (state_reg == LOAD) && bus.in_valid;
  assign pe_clear = (state_reg == CLEAR);
  assign pe_en    = (state_reg == LOAD) || (state_reg == DRAIN);

  assign bus.busy         = busy_c;
  assign bus.in_ready     = ready_c;
  assign bus.result_valid = rvalid_c;
  assign bus.done         = done_reg;
  assign bus.c_flat       = c_flat_w;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and status decode.
  always_comb begin
    state_next = state_reg;
    busy_c     = 1'b0;
    ready_c    = 1'b0;
    rvalid_c   = 1'b0;
    unique case (state_reg)
      IDLE:  if (bus.start) state_next = CLEAR;
      CLEAR: begin
        busy_c     = 1'b1;
        state_next = (beats_left_reg == '0) ? DRAIN : LOAD;
      end
      LOAD: begin
        busy_c  = 1'b1;
        ready_c = 1'b1;
        if (bus.in_valid && beats_left_reg == KW'(1)) state_next = DRAIN;
      end
      DRAIN: begin
        busy_c = 1'b1;
        if (drain_cnt_reg == '0) state_next = DONE;
      end
      DONE: begin
        rvalid_c = 1'b1;
        if (bus.start) state_next = CLEAR;
      end
      default: state_next = IDLE;
    endcase
  end

  // Job parameters, beat/drain counters and the one-cycle done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_left_reg  <= '0;
      drain_cnt_reg   <= DCW'(DRAIN_LEN - 1);
      signed_mode_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= (state_next == DONE) && (state_reg != DONE);
      if ((state_reg == IDLE || state_reg == DONE) && bus.start) begin
        beats_left_reg  <= bus.k_len;
        signed_mode_reg <= bus.signed_mode;
      end else if (beat) begin
        beats_left_reg <= beats_left_reg - 1'b1;
      end
      if (state_reg == DRAIN) drain_cnt_reg <= drain_cnt_reg - 1'b1;
      else                    drain_cnt_reg <= DCW'(DRAIN_LEN - 1);
    end
  end

  // Row skew: lane i delays A element i by i cycles; idle cycles inject zeros.
  for (genvar gi = 0; gi < N; gi++) begin : g_row_skew
    logic [DATA_W-1:0] lane_in;
    assign lane_in = beat ? bus.a_col[gi*DATA_W +: DATA_W] : '0;
    if (gi == 0) begin : g_direct
      assign a_h[gi][0] = lane_in;
    end else begin : g_delay
      logic [DATA_W-1:0] sr [gi];
      // Shift the row lane once per active cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < gi; d++) sr[d] <= '0;
        end else if (pe_clear) begin
          for (int d = 0; d < gi; d++) sr[d] <= '0;
        end else if (pe_en) begin
          sr[0] <= lane_in;
          for (int d = 1; d < gi; d++) sr[d] <= sr[d-1];
        end
      end
      assign a_h[gi][0] = sr[gi-1];
    end
  end

  // Column skew: lane j delays B element j by j cycles.
  for (genvar gj = 0; gj < N; gj++) begin : g_col_skew
    logic [DATA_W-1:0] lane_in;
    assign lane_in = beat ? bus.b_row[gj*DATA_W +: DATA_W] : '0;
    if (gj == 0) begin : g_direct
      assign b_v[0][gj] = lane_in;
    end else begin : g_delay
      logic [DATA_W-1:0] sr [gj];
      // Shift the column lane once per active cycle.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int d = 0; d < gj; d++) sr[d] <= '0;
        end else if (pe_clear) begin
          for (int d = 0; d < gj; d++) sr[d] <= '0;
        end else if (pe_en) begin
          sr[0] <= lane_in;
          for (int d = 1; d < gj; d++) sr[d] <= sr[d-1];
        end
      end
      assign b_v[0][gj] = sr[gj-1];
    end
  end

  // PE grid; operands leaving the right and bottom edges are discarded.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    assign unused_a_edge[gi] = ^a_h[gi][N];
    assign unused_b_edge[gi] = ^b_v[N][gi];
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      localparam int FI = flat_idx(gi, gj, N);
      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk         (clk),
        .rst         (rst),
        .clear       (pe_clear),
        .en          (pe_en),
        .signed_mode (signed_mode_reg),
        .a_in        (a_h[gi][gj]),
        .b_in        (b_v[gi][gj]),
        .a_out       (a_h[gi][gj+1]),
        .b_out       (b_v[gi+1][gj]),
        .acc         (c_flat_w[FI*ACC_W +: ACC_W])
      );
    end
  end
endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Scoreboard bench for systolic_matmul_engine (N=4, 8-bit operands, 32-bit results).
module tb_systolic_matmul_engine;
  localparam int N = 4, DW = 8, AW = 32, KMAX = 255;

  typedef int mat_t [4][4];
  typedef int cvec_t [16];
  typedef struct packed {
    logic [16*32-1:0] c;
    int latency;
    int load_cycles;
    int start_cyc;
    int ready_base;
    int id;
  } exp_t;

  logic clk, rst;
  int   cyc, checks, failures, ready_cnt, timeout_cnt;
  bit   finish_req, prev_done;
  exp_t exp_q[$];

  systolic_matmul_engine_if #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_MAX(KMAX)) bus ();

  systolic_matmul_engine #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_MAX(KMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [31:0] pack(input mat_t m, input int k, input bit is_a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = is_a ? 8'(m[i][k]) : 8'(m[k][i]);
    return v;
  endfunction

  // Monitor: checks reset outputs, and on every done pulse pops and compares one expectation.
  initial begin : monitor
    exp_t x;
    int   lat, nbad, first_bad;
    checks = 0; failures = 0; ready_cnt = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_q.delete();
        prev_done = 0;
        checks++;
        if ({bus.busy, bus.in_ready, bus.done, bus.result_valid} != 4'b0 || bus.c_flat != '0) begin
          failures++;
          $display("FAIL reset_outputs busy=%0b in_ready=%0b done=%0b result_valid=%0b c_nonzero=%0b required all 0",
                   bus.busy, bus.in_ready, bus.done, bus.result_valid, bus.c_flat != '0);
        end
      end else begin
        if (bus.in_ready) ready_cnt++;
        if (prev_done) begin
          checks++;
          if (bus.done) begin
            failures++;
            $display("FAIL done_pulse done=1 on second DONE cycle, required 0");
          end
        end
        prev_done = bus.done;
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_done at cyc=%0d with no job outstanding", cyc);
          end else begin
            x = exp_q.pop_front();
            lat = cyc - x.start_cyc;
            checks++;
            if (lat != x.latency) begin
              failures++;
              $display("FAIL job%0d_latency got=%0d required=%0d", x.id, lat, x.latency);
            end
            checks++;
            if (ready_cnt - x.ready_base != x.load_cycles) begin
              failures++;
              $display("FAIL job%0d_in_ready_cycles got=%0d required=%0d", x.id, ready_cnt - x.ready_base, x.load_cycles);
            end
            checks++;
            if (bus.result_valid !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
              failures++;
              $display("FAIL job%0d_status result_valid=%0b busy=%0b in_ready=%0b required 1/0/0",
                       x.id, bus.result_valid, bus.busy, bus.in_ready);
            end
            nbad = 0; first_bad = -1;
            for (int e = 0; e < 16; e++) begin
              if (bus.c_flat[e*32 +: 32] !== x.c[e*32 +: 32]) begin
                nbad++;
                if (first_bad < 0) first_bad = e;
              end
            end
            checks++;
            if (nbad != 0) begin
              failures++;
              $display("FAIL job%0d_c_matrix %0d wrong, first C[%0d] got=%0d required=%0d", x.id, nbad,
                       first_bad, $signed(bus.c_flat[first_bad*32 +: 32]), $signed(x.c[first_bad*32 +: 32]));
            end
            $display("job %0d done latency=%0d C00=%0d C33=%0d", x.id, lat,
                     $signed(bus.c_flat[31:0]), $signed(bus.c_flat[15*32 +: 32]));
          end
        end
      end
      if (finish_req) begin
        checks++;
        if (exp_q.size() != 0 || timeout_cnt != 0) begin
          failures++;
          $display("FAIL end_state outstanding=%0d timeouts=%0d required 0/0", exp_q.size(), timeout_cnt);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (cyc > 50000) begin
        checks++; failures++;
        $display("FAIL watchdog cyc=%0d limit=50000", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic run_job(input int id, input int k, input bit sm, input mat_t a, input mat_t b,
                         input int stall_mask, input bit glitch, input int abort_rel,
                         input cvec_t cexp, input int lat, input int loadc);
    exp_t x;
    int   rel, kk, guard;
    bit   seen, stalled;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.k_len = 8'(k); bus.signed_mode = sm;
    x.id = id; x.latency = lat; x.load_cycles = loadc; x.start_cyc = cyc; x.ready_base = ready_cnt;
    for (int e = 0; e < 16; e++) x.c[e*32 +: 32] = cexp[e];
    exp_q.push_back(x);
    @(posedge clk); #1;
    bus.start = 1'b0; rel = 1; kk = 0; guard = 0;
    while (kk < k && guard < 400) begin
      stalled = (rel < 32) ? stall_mask[rel] : 1'b0;
      bus.start    = glitch && (rel == 3);
      bus.in_valid = !stalled;
      bus.a_col    = pack(a, kk, 1'b1);
      bus.b_row    = pack(b, kk, 1'b0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) kk++;
      @(posedge clk); #1;
      rel++; guard++;
    end
    bus.in_valid = 1'b0; bus.start = 1'b0; bus.a_col = '0; bus.b_row = '0;
    if (kk < k) begin
      timeout_cnt++;
      $display("FAIL job%0d_load_timeout beats=%0d required=%0d", id, kk, k);
    end
    seen = 0; guard = 0;
    while (!seen && guard < 400) begin
      if (abort_rel > 0 && rel == abort_rel) begin
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        return;
      end
      bus.start = glitch && (rel == k + 5);
      @(negedge clk);
      if (bus.result_valid) seen = 1;
      else begin
        @(posedge clk); #1;
        rel++; guard++;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      timeout_cnt++;
      $display("FAIL job%0d_done_timeout result_valid never seen within 400 cycles", id);
    end
  endtask

  initial begin : driver
    mat_t  a1, b1, af, b2, ai, bi, z;
    cvec_t c1, cneg, cpos, czero, cid;
    rst = 1'b1; timeout_cnt = 0; finish_req = 0;
    bus.start = 1'b0; bus.k_len = '0; bus.signed_mode = 1'b0;
    bus.in_valid = 1'b0; bus.a_col = '0; bus.b_row = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        a1[i][j] = i + j + 1;
        b1[i][j] = i + j + 5;
        af[i][j] = 255;
        b2[i][j] = 2;
        ai[i][j] = (i == j) ? 1 : 0;
        bi[i][j] = 4 * i + j + 1;
        z[i][j]  = 0;
      end
    end
    c1    = '{70, 80, 90, 100, 96, 110, 124, 138, 122, 140, 158, 176, 148, 170, 192, 214};
    cneg  = '{-8, -8, -8, -8, -8, -8, -8, -8, -8, -8, -8, -8, -8, -8, -8, -8};
    cpos  = '{2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040, 2040};
    czero = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    cid   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};

    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    run_job(1, 4, 1'b1, a1, b1, 0, 1'b0, 0, c1, 16, 4);
    run_job(2, 4, 1'b1, a1, b1, (1 << 3) | (1 << 5) | (1 << 6), 1'b0, 0, c1, 19, 7);
    run_job(3, 4, 1'b1, af, b2, 0, 1'b0, 0, cneg, 16, 4);
    run_job(4, 4, 1'b0, af, b2, 0, 1'b0, 0, cpos, 16, 4);
    run_job(5, 0, 1'b1, z, z, 0, 1'b0, 0, czero, 12, 0);
    run_job(6, 4, 1'b1, ai, bi, 0, 1'b0, 0, cid, 16, 4);
    run_job(7, 4, 1'b1, a1, b1, 0, 1'b0, 10, c1, 16, 4);
    run_job(8, 4, 1'b1, a1, b1, 0, 1'b0, 0, c1, 16, 4);
    run_job(9, 4, 1'b1, a1, b1, 0, 1'b1, 0, c1, 16, 4);

    repeat (2) @(posedge clk);
    #1 finish_req = 1'b1;
  end
endmodule
